// File: rtl/keycode_event_gen.sv
// Turns the PIO keycode level into press / auto-repeat events.
// Repeat timing is counted in frame ticks; events are queued in a show-ahead FIFO.
module keycode_event_gen #(
    parameter int unsigned REPEAT_DELAY = 30,
    parameter int unsigned REPEAT_RATE  = 6,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode_in,
    input  logic       frame_tick,
    input  logic       evt_ready,
    input  logic       clr_overflow,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_repeat,
    output logic       key_held,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DELAY8 = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE8  = 8'(REPEAT_RATE);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t     state, state_n;
    logic [7:0] cur_code, code_n;
    logic [7:0] cnt, cnt_n;
    logic       push;
    logic [7:0] push_code;
    logic       push_rep;

    // Precedence within a cycle: release, then code change, then frame tick.
    always_comb begin
        state_n   = state;
        code_n    = cur_code;
        cnt_n     = cnt;
        push      = 1'b0;
        push_code = keycode_in;
        push_rep  = 1'b0;
        case (state)
            IDLE: begin
                if (keycode_in != 8'h00) begin
                    push    = 1'b1;
                    code_n  = keycode_in;
                    cnt_n   = DELAY8;
                    state_n = HOLD;
                end
            end
            default: begin
                if (keycode_in == 8'h00) begin
                    state_n = IDLE;
                end else if (keycode_in != cur_code) begin
                    push    = 1'b1;
                    code_n  = keycode_in;
                    cnt_n   = DELAY8;
                    state_n = HOLD;
                end else if (frame_tick) begin
                    if (cnt == 8'd1) begin
                        push      = 1'b1;
                        push_code = cur_code;
                        push_rep  = 1'b1;
                        cnt_n     = RATE8;
                        state_n   = REPEAT;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_code <= '0;
            cnt      <= '0;
            key_held <= 1'b0;
        end else begin
            state    <= state_n;
            cur_code <= code_n;
            cnt      <= cnt_n;
            key_held <= (state_n != IDLE);
        end
    end

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n, count;
    logic        full, pop, push_ok;
    logic [8:0]  head_n;

    always_comb begin
        count   = wr_ptr - rd_ptr;
        full    = (count == DEPTH_P);
        pop     = evt_valid && evt_ready;
        push_ok = push && (!full || pop);
        wr_n    = wr_ptr + (AW+1)'(push_ok);
        rd_n    = rd_ptr + (AW+1)'(pop);
        // Next head may be the entry being written this cycle (empty FIFO case).
        if (push_ok && (rd_n == wr_ptr))
            head_n = {push_code, push_rep};
        else
            head_n = mem[rd_n[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= {push_code, push_rep};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_repeat <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr    <= wr_n;
            rd_ptr    <= rd_n;
            evt_valid <= (wr_n != rd_n);
            if (wr_n != rd_n)
                {evt_code, evt_repeat} <= head_n;
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keycode_event_gen.sv
// Scoreboard bench for keycode_event_gen: expected events are queued as keys are
// driven and compared as the consumer pops them.
module tb_keycode_event_gen;

    logic       clk;
    logic       reset_n;
    logic [7:0] keycode_in;
    logic       frame_tick;
    logic       evt_ready;
    logic       clr_overflow;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_repeat;
    logic       key_held;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int seen     = 0;
    logic [8:0] sb [$];

    keycode_event_gen #(
        .REPEAT_DELAY(3),
        .REPEAT_RATE (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .keycode_in  (keycode_in),
        .frame_tick  (frame_tick),
        .evt_ready   (evt_ready),
        .clr_overflow(clr_overflow),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_repeat  (evt_repeat),
        .key_held    (key_held),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer side: every accepted event is checked against the scoreboard head.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (reset_n && evt_valid && evt_ready) begin
            checks++;
            seen++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got=%h rep=%b expected=none", evt_code, evt_repeat);
            end else begin
                exp = sb.pop_front();
                if ({evt_code, evt_repeat} !== exp) begin
                    failures++;
                    $display("FAIL event_order got=%h rep=%b expected=%h rep=%b",
                             evt_code, evt_repeat, exp[8:1], exp[0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic drain(input string name);
        evt_ready = 1'b1;
        repeat (20) step();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL %s_leftover got=%0d expected=0 outstanding", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; keycode_in = '0; frame_tick = 0; evt_ready = 0; clr_overflow = 0;
        step(); step();
        checks++;
        if ({evt_valid, evt_code, evt_repeat, key_held, overflow} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=000",
                     {evt_valid, evt_code, evt_repeat, key_held, overflow});
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_press_release();
        int s0 = seen;
        evt_ready = 1'b1;
        keycode_in = 8'h1A; sb.push_back({8'h1A, 1'b0});
        step();
        checks++;
        if (key_held !== 1'b1) begin
            failures++; $display("FAIL press_key_held got=%b expected=1", key_held);
        end
        keycode_in = 8'h00;
        step();
        checks++;
        if (key_held !== 1'b0) begin
            failures++; $display("FAIL release_key_held got=%b expected=0", key_held);
        end
        drain("press_release");
        checks++;
        if (seen - s0 !== 1) begin
            failures++; $display("FAIL press_release_count got=%0d expected=1", seen - s0);
        end
    endtask

    task automatic test_repeat();
        int s0 = seen;
        evt_ready = 1'b1;
        keycode_in = 8'h04; sb.push_back({8'h04, 1'b0});
        step();
        for (int i = 1; i <= 9; i++) begin
            if (i >= 3 && (i - 3) % 2 == 0) sb.push_back({8'h04, 1'b1});
            tick();
            step();
        end
        keycode_in = 8'h00;
        drain("repeat");
        checks++;
        if (seen - s0 !== 5) begin
            failures++; $display("FAIL repeat_count got=%0d expected=5", seen - s0);
        end
    endtask

    task automatic test_change_on_tick();
        int s0 = seen;
        evt_ready = 1'b1;
        keycode_in = 8'h04; sb.push_back({8'h04, 1'b0});
        step();
        tick(); tick();
        keycode_in = 8'h07; frame_tick = 1'b1; sb.push_back({8'h07, 1'b0});
        step();
        frame_tick = 1'b0;
        step();
        tick(); tick();
        checks++;
        if (seen - s0 !== 2) begin
            failures++; $display("FAIL change_early_repeat got=%0d expected=2", seen - s0);
        end
        sb.push_back({8'h07, 1'b1});
        tick();
        keycode_in = 8'h00;
        drain("change_on_tick");
        checks++;
        if (seen - s0 !== 3) begin
            failures++; $display("FAIL change_count got=%0d expected=3", seen - s0);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keycode_in = codes[i];
            if (i < 4) sb.push_back({codes[i], 1'b0});
            step();
            if (i == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++; $display("FAIL overflow_at_full got=%b expected=0", overflow);
                end
            end
        end
        checks++;
        if ({evt_valid, overflow, evt_code, evt_repeat} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin
            failures++;
            $display("FAIL overflow_set got=v%b o%b %h r%b expected=v1 o1 11 r0",
                     evt_valid, overflow, evt_code, evt_repeat);
        end
        keycode_in = 8'h66; clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++; $display("FAIL overflow_set_wins got=%b expected=1", overflow);
        end
        keycode_in = 8'h00; clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL overflow_clear got=%b expected=0", overflow);
        end
        drain("overflow");
    endtask

    task automatic test_back_to_back();
        int s0 = seen;
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) evt_ready = 1'b1;
            keycode_in = 8'h31 + 8'(i);
            sb.push_back({8'h31 + 8'(i), 1'b0});
            step();
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL full_pop_overflow got=%b expected=0", overflow);
        end
        keycode_in = 8'h00;
        drain("back_to_back");
        checks++;
        if (seen - s0 !== 8) begin
            failures++; $display("FAIL back_to_back_count got=%0d expected=8", seen - s0);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        evt_ready = 1'b0;
        keycode_in = 8'h42; sb.push_back({8'h42, 1'b0});
        step();
        tick(); tick();
        sb.push_back({8'h42, 1'b1});
        tick();
        checks++;
        if ({key_held, evt_valid} !== 2'b11) begin
            failures++; $display("FAIL pre_reset_state got=%b expected=11", {key_held, evt_valid});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({evt_valid, evt_code, evt_repeat, key_held, overflow} !== 12'h000) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h expected=000",
                     {evt_valid, evt_code, evt_repeat, key_held, overflow});
        end
        sb.delete();
        s0 = seen;
        step();
        reset_n = 1'b1;
        sb.push_back({8'h42, 1'b0});
        step();
        drain("reset_mid");
        keycode_in = 8'h00;
        drain("reset_mid_release");
        checks++;
        if (seen - s0 !== 1) begin
            failures++; $display("FAIL reset_mid_count got=%0d expected=1", seen - s0);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_repeat();
        test_change_on_tick();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keycode_event_gen.md
Name: keycode_event_gen

Overview:
- Consumes the 8-bit keycode level driven by the Nios keycode PIO and turns it into discrete key events: one press event on each new non-zero code, then auto-repeat events while the key is held.
- Repeat timing is counted in frame ticks (one pulse per video frame).
- Events are queued in a small show-ahead FIFO and offered to the simulation control logic over a valid/ready handshake.

Parameters:
- REPEAT_DELAY, 30: frame ticks from the press event to the first repeat event; legal range 1..255.
- REPEAT_RATE, 6: frame ticks between consecutive repeat events; legal range 1..255.
- FIFO_DEPTH, 4: event queue depth; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- keycode_in  in  8  keycode level from the PIO; 0x00 means no key.
- frame_tick  in  1  single-cycle pulse, once per frame.
- evt_ready  in  1  consumer accepts the head event.
- clr_overflow  in  1  single-cycle pulse; clears overflow.
- evt_valid  out  1  the FIFO holds at least one event.
- evt_code  out  8  keycode of the head event.
- evt_repeat  out  1  head event type: 0 = press, 1 = auto-repeat.
- key_held  out  1  high while the FSM is not in IDLE.
- overflow  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-low, ports named clk and reset_n.
  - Reset clears: state = IDLE, cur_code = 0, counter = 0, FIFO empty.
  - Reset outputs: evt_valid = 0, evt_code = 0, evt_repeat = 0, key_held = 0, overflow = 0.
  - Reset mid-operation discards all queued events; no event is generated on reset release.
- keycode_in is synchronous to clk; no synchroniser. cur_code is the registered copy of the last accepted non-zero code.
- FSM state IDLE:
  - keycode_in != 0 → push press event {keycode_in, 0}, cur_code ← keycode_in, cnt ← REPEAT_DELAY, go to HOLD.
- FSM state HOLD:
  - keycode_in == 0 → go to IDLE; no release event.
  - keycode_in != 0 and != cur_code → push press event for the new code, cnt ← REPEAT_DELAY, stay in HOLD.
  - Else on frame_tick: if cnt == 1, push repeat event {cur_code, 1}, cnt ← REPEAT_RATE, go to REPEAT; otherwise cnt ← cnt − 1.
- FSM state REPEAT:
  - Same rules as HOLD.
  - On terminal tick: push repeat event and reload cnt ← REPEAT_RATE.
  - A code change pushes a press event and returns to HOLD with cnt ← REPEAT_DELAY.
- Same-cycle precedence: release > code change > frame_tick. A tick coinciding with a code change or release is ignored.
- cnt is 8 bits and does not wrap: it reloads on the terminal tick.
- Latency: keycode change sampled at edge N → event visible on evt_valid/evt_code after edge N (cycle N+1) when the FIFO was empty.
- FIFO:
  - Show-ahead: evt_code/evt_repeat always reflect the head entry.
  - Pop on evt_valid && evt_ready. evt_ready while empty has no effect.
  - Push while full without a same-cycle pop: event dropped, overflow ← 1, FIFO contents unchanged.
  - Push while full with a same-cycle pop: push accepted, no overflow.
  - Push and pop on an empty FIFO: event enqueued (no bypass), evt_valid = 1 next cycle.
  - Pointers use log2(FIFO_DEPTH)+1 bits; wrap-around is natural modulo.
- overflow: set on a drop, cleared by clr_overflow. Set wins if both occur in the same cycle.
- key_held = (state != IDLE), registered.
- evt_code/evt_repeat hold their last value when empty.

Test Plan:
- Press 0x1A at t0 with evt_ready=1, then release before any tick → exactly one event {0x1A, press}; key_held 1→0; no further events.
- REPEAT_DELAY=3, REPEAT_RATE=2; hold 0x04 for 9 ticks with evt_ready=1 → press, then repeats after ticks 3, 5, 7, 9; 5 events total.
- Hold 0x04, switch to 0x07 on the same cycle as the terminal frame_tick → press event {0x07}, no repeat event for 0x04; next repeat 3 ticks later.
- evt_ready=0, FIFO_DEPTH=4, generate 5 press events (alternating codes) → evt_valid=1, FIFO holds first 4 in order, overflow=1; assert clr_overflow together with a 6th push → overflow stays 1.
- FIFO full with evt_ready=1 and push in the same cycle → no drop, overflow stays 0, order preserved through pointer wrap (drain 8 events).
- Assert reset_n low mid-REPEAT with 2 queued events → outputs immediately 0, FIFO empty; after release with key still held → one press event, not a repeat.
